spi_frame_writer: RTL
=====================

Name: spi_frame_writer

Overview:
- SPI-slave front end that deserialises MOSI into 16-bit words and writes them as fixed-length frames into port A of the ping-pong RAM.
- Drives addra/wea/dina, pulses finisha at frame end, and waits on readya before starting each frame.
- Sits directly upstream of the ping-pong RAM write port, sharing its clock.

Parameters:
DATA_W, 16, SPI word width and dina width
ADDR_W, 7, RAM port A address width
FRAME_WORDS, 64, words per frame (must be ≤ 2^ADDR_W)
SYNC_STAGES, 2, synchroniser depth on spi_sclk/spi_cs_n/spi_mosi (≥2)

Ports:
clk  in  1  system clock, same clock as RAM port A
rst  in  1  synchronous active-high reset
spi_sclk  in  1  SPI clock, asynchronous, frequency ≤ clk/4
spi_cs_n  in  1  SPI chip select, active low
spi_mosi  in  1  SPI data in
readya  in  1  RAM: a write bank is free
addra  out  ADDR_W  RAM write address
wea  out  1  RAM write enable, single-cycle pulse per word
dina  out  DATA_W  RAM write data
finisha  out  1  frame complete, single-cycle pulse
frame_drop  out  1  pulse: a received word was discarded because no bank was free
bit_err  out  1  pulse: cs_n rose with a partial word pending
busy  out  1  high while a frame is being filled

Behaviour:
- Reset: one clock, synchronous, active-high. All outputs 0, bit counter 0, address 0, FSM in WAIT_BUF, synchroniser flops cleared (spi_cs_n flops cleared to 1).
- SPI mode 0, MSB first.
  - All three SPI inputs pass through SPI_SYNC_STAGES flops, so they stay mutually aligned.
  - An SCLK rising edge is detected from the last sync stage versus its registered copy; MOSI is sampled on that edge only while synced cs_n = 0.
- Bit counter:
  - Counts 0..DATA_W-1 and clears whenever synced cs_n = 1.
  - At the 16th bit, an internal word_valid pulses for one cycle with the assembled word.
- Partial word: if synced cs_n rises while the bit count ≠ 0, the bits are discarded, bit_err pulses 1 cycle, and no write occurs.
- Latency: wea rises exactly SYNC_STAGES+2 clk cycles after the clk edge at which the 16th sclk rising level is first captured by sync stage 1; dina/addra are valid in the same cycle.
- FSM states:
  - WAIT_BUF: readya sampled every cycle.
    - readya=1 → FILL, with addra=0.
    - A word_valid with readya=0 → frame_drop pulse, word lost.
    - word_valid and readya=1 in the same cycle → the word is written at addr 0 in the next cycle and the FSM enters FILL.
  - FILL: busy=1; readya ignored.
    - Each word_valid → wea=1 for 1 cycle, dina=word, addra=current pointer, then pointer+1.
    - After write FRAME_WORDS-1 → FINISH.
  - FINISH: wea=0, finisha=1 for exactly 1 cycle (the cycle after the last wea), addra returns to 0 → HOLD.
  - HOLD: 1 cycle so the RAM can swap banks and update readya → WAIT_BUF.
  - A word_valid arriving in FINISH/HOLD is held in a 1-word skid register and written at addr 0 once WAIT_BUF sees readya=1. If the skid register is already full, frame_drop pulses.
- Frames span any number of CS transactions. cs_n activity does not reset the word pointer; only rst or frame completion does.
- Address arithmetic is unsigned ADDR_W bits and never wraps inside a frame; pointer equality with FRAME_WORDS-1 terminates the frame.
- Reset mid-frame: partial frame abandoned, no finisha, next frame starts at addr 0.

Optional Feature:
SPI_FRAME_WRITER_DROP_CNT_EN:
- Defined: adds output drop_cnt [15:0], a saturating count of frame_drop pulses, cleared by rst; holds at 16'hFFFF.
- Undefined: port and counter absent; only the frame_drop pulse exists.

Test Plan:
1. rst 2 cycles, readya=1, one CS burst of 64 words 0x0000..0x003F at sclk=clk/8 → 64 wea pulses with addra 0..63, dina=i; finisha single pulse the cycle after addra=63 write; addra=0 afterwards.
2. readya=0, send 3 words → no wea, 3 frame_drop pulses, drop_cnt=3 (macro on); raise readya, send 16'hBEEF → wea at addra=0, dina=16'hBEEF.
3. Send 9 bits then raise cs_n → bit_err 1 pulse, no wea; then full word 16'hA5C3 → written at the unchanged addra.
4. 32 words in CS transaction 1, cs_n high 50 cycles, 32 words in transaction 2 → one frame, addra continuous 0..63, exactly one finisha.
5. Assert rst for 1 cycle after the 20th wea → all outputs 0 the next cycle; following 64 words form a full frame starting at addra=0.
6. 128 back-to-back words at sclk=clk/4 with readya=1 → 2 finisha pulses, 128 wea, zero frame_drop (skid register absorbs the FINISH/HOLD gap).

Source files
------------

// File: rtl/spi_frame_writer.sv
// SPI mode-0 slave that packs MOSI into DATA_W-bit words and writes fixed-length
// frames into RAM port A. Define SPI_FRAME_WRITER_DROP_CNT_EN to add drop_cnt.
module spi_frame_writer #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 7,
    parameter int FRAME_WORDS = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    input  logic              readya,
    output logic [ADDR_W-1:0] addra,
    output logic              wea,
    output logic [DATA_W-1:0] dina,
    output logic              finisha,
    output logic              frame_drop,
    output logic              bit_err,
`ifdef SPI_FRAME_WRITER_DROP_CNT_EN
    output logic [15:0]       drop_cnt,
`endif
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_W - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

    typedef enum logic [1:0] {
        WAIT_BUF,
        FILL,
        FINISH,
        HOLD
    } state_t;

    // ---------------- input synchronisers ----------------
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (rst) begin
                        sclk_sync_q[gi] <= 1'b0;
                        cs_sync_q[gi]   <= 1'b1;
                        mosi_sync_q[gi] <= 1'b0;
                    end else begin
                        sclk_sync_q[gi] <= spi_sclk;
                        cs_sync_q[gi]   <= spi_cs_n;
                        mosi_sync_q[gi] <= spi_mosi;
                    end
                end
            end else begin : g_rest
                always_ff @(posedge clk) begin
                    if (rst) begin
                        sclk_sync_q[gi] <= 1'b0;
                        cs_sync_q[gi]   <= 1'b1;
                        mosi_sync_q[gi] <= 1'b0;
                    end else begin
                        sclk_sync_q[gi] <= sclk_sync_q[gi-1];
                        cs_sync_q[gi]   <= cs_sync_q[gi-1];
                        mosi_sync_q[gi] <= mosi_sync_q[gi-1];
                    end
                end
            end
        end
    endgenerate

    // Edge detect is registered together with cs_n/mosi so all three stay aligned.
    logic sclk_last_q;
    logic rise_q;
    logic cs_q;
    logic mosi_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_last_q <= 1'b0;
            rise_q      <= 1'b0;
            cs_q        <= 1'b1;
            mosi_q      <= 1'b0;
        end else begin
            sclk_last_q <= sclk_sync_q[SYNC_STAGES-1];
            rise_q      <= sclk_sync_q[SYNC_STAGES-1] & ~sclk_last_q;
            cs_q        <= cs_sync_q[SYNC_STAGES-1];
            mosi_q      <= mosi_sync_q[SYNC_STAGES-1];
        end
    end

    // ---------------- deserialiser ----------------
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              word_valid_q, word_valid_d;
    logic              bit_err_q, bit_err_d;

    always_comb begin
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        word_valid_d = 1'b0;
        bit_err_d    = 1'b0;
        if (cs_q) begin
            bit_cnt_d = '0;
            bit_err_d = (bit_cnt_q != '0);
        end else if (rise_q) begin
            shift_d = {shift_q[DATA_W-2:0], mosi_q};
            if (bit_cnt_q == LAST_BIT) begin
                bit_cnt_d    = '0;
                word_valid_d = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            word_valid_q <= 1'b0;
            bit_err_q    <= 1'b0;
        end else begin
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            word_valid_q <= word_valid_d;
            bit_err_q    <= bit_err_d;
        end
    end

    // ---------------- frame writer FSM ----------------
    // shift_q holds the completed word while word_valid_q is high.
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              skid_full_q, skid_full_d;
    logic              wea_q, wea_d;
    logic [DATA_W-1:0] dina_q, dina_d;
    logic [ADDR_W-1:0] addra_q, addra_d;
    logic              finisha_q, finisha_d;
    logic              frame_drop_q, frame_drop_d;
    logic              accept;
    logic              do_write;
    logic [DATA_W-1:0] wr_data;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        skid_d       = skid_q;
        skid_full_d  = skid_full_q;
        wea_d        = 1'b0;
        dina_d       = dina_q;
        addra_d      = addra_q;
        finisha_d    = 1'b0;
        frame_drop_d = 1'b0;
        do_write     = 1'b0;
        wr_data      = shift_q;
        accept       = (state_q == FILL) || ((state_q == WAIT_BUF) && readya);

        case (state_q)
            WAIT_BUF: begin
                if (readya) begin
                    state_d = FILL;
                    ptr_d   = '0;
                    addra_d = '0;
                end
            end
            FINISH: begin
                addra_d   = '0;
                finisha_d = 1'b1;
                state_d   = HOLD;
            end
            HOLD: begin
                state_d = WAIT_BUF;
            end
            default: begin
            end
        endcase

        if (accept) begin
            // A parked word always goes first; a simultaneous new word refills the skid.
            if (skid_full_q) begin
                do_write = 1'b1;
                wr_data  = skid_q;
                if (word_valid_q) begin
                    skid_d = shift_q;
                end else begin
                    skid_full_d = 1'b0;
                end
            end else if (word_valid_q) begin
                do_write = 1'b1;
                wr_data  = shift_q;
            end
        end else if (word_valid_q) begin
            if (state_q == WAIT_BUF || skid_full_q) begin
                frame_drop_d = 1'b1;
            end else begin
                skid_full_d = 1'b1;
                skid_d      = shift_q;
            end
        end

        if (do_write) begin
            wea_d   = 1'b1;
            dina_d  = wr_data;
            addra_d = ptr_q;
            if (ptr_q == LAST_ADDR) begin
                state_d = FINISH;
                ptr_d   = '0;
            end else begin
                state_d = FILL;
                ptr_d   = ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= WAIT_BUF;
            ptr_q        <= '0;
            skid_q       <= '0;
            skid_full_q  <= 1'b0;
            wea_q        <= 1'b0;
            dina_q       <= '0;
            addra_q      <= '0;
            finisha_q    <= 1'b0;
            frame_drop_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            skid_q       <= skid_d;
            skid_full_q  <= skid_full_d;
            wea_q        <= wea_d;
            dina_q       <= dina_d;
            addra_q      <= addra_d;
            finisha_q    <= finisha_d;
            frame_drop_q <= frame_drop_d;
        end
    end

`ifdef SPI_FRAME_WRITER_DROP_CNT_EN
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else if (frame_drop_q && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

    assign addra      = addra_q;
    assign wea        = wea_q;
    assign dina       = dina_q;
    assign finisha    = finisha_q;
    assign frame_drop = frame_drop_q;
    assign bit_err    = bit_err_q;
    assign busy       = (state_q == FILL);

endmodule
